hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/hazard_detect.sv | 45 ++++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline-control types: hazard FSM states and forward-select codes
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    // Register 0 is hard-wired, so a write to it never forwards; M is younger than W and wins.
    function automatic fwd_sel_t ex_fwd_sel(
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w,
        input logic [4:0] src
    );
        if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src))
            return FWD_M;
        else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational operand forwarding and load-use / branch hazard detection
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       mem_to_reg_e,
    input  logic       mem_to_reg_m,
    input  logic       branch_d,
    output fwd_sel_t   forward_a_e,
    output fwd_sel_t   forward_b_e,
    output logic       forward_a_d,
    output logic       forward_b_d,
    output logic       lw_stall,
    output logic       br_stall
);

    logic m_valid;
    logic e_hits_d;
    logic m_hits_d;

    assign m_valid = reg_write_m && (write_reg_m != 5'd0);

    assign forward_a_e = ex_fwd_sel(reg_write_m, write_reg_m, reg_write_w, write_reg_w, rs_e);
    assign forward_b_e = ex_fwd_sel(reg_write_m, write_reg_m, reg_write_w, write_reg_w, rt_e);

    assign forward_a_d = m_valid && (write_reg_m == rs_d);
    assign forward_b_d = m_valid && (write_reg_m == rt_d);

    assign lw_stall = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));

    // Branch compares in D, so it must wait for an ALU result still in E or a load still in M.
    assign e_hits_d = reg_write_e  && ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    assign m_hits_d = mem_to_reg_m && ((write_reg_m == rs_d) || (write_reg_m == rt_d));
    assign br_stall = branch_d && (e_hits_d || m_hits_d);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with memory-wait and multiply/divide busy FSM
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  write_reg_e,
    input  logic [4:0]  write_reg_m,
    input  logic [4:0]  write_reg_w,
    input  logic        reg_write_e,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic        mem_to_reg_e,
    input  logic        mem_to_reg_m,
    input  logic        branch_d,
    input  logic        pc_src_d,
    input  logic        jump_d,
    input  logic        mem_req_m,
    input  logic        mem_ready,
    input  logic        md_start_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_w,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        forward_a_d,
    output logic        forward_b_d,
    output logic [31:0] stall_cycles
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] md_cnt;
    logic [CW-1:0] md_cnt_next;
    logic          lw_stall;
    logic          br_stall;
    logic          mem_miss;
    logic          mem_hold;
    logic          md_accept;

    hazard_detect u_detect (
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .branch_d     (branch_d),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .forward_a_d  (forward_a_d),
        .forward_b_d  (forward_b_d),
        .lw_stall     (lw_stall),
        .br_stall     (br_stall)
    );

    assign mem_miss  = mem_req_m && !mem_ready;
    // A pending miss freezes the whole pipe from its first cycle, before the FSM has moved.
    assign mem_hold  = (state == MEM_WAIT) || mem_miss;
    assign md_accept = (state == RUN) && md_start_e && !mem_miss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mem_miss)
                    state_next = MEM_WAIT;
                else if (md_start_e)
                    state_next = MD_BUSY;
            end
            MEM_WAIT: begin
                if (mem_ready)
                    state_next = (md_cnt != '0) ? MD_BUSY : RUN;
            end
            MD_BUSY: begin
                if (mem_miss)
                    state_next = MEM_WAIT;
                else if (md_cnt == '0)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // The divider keeps running through memory waits, so the count never pauses, only saturates.
    always_comb begin
        md_cnt_next = md_cnt;
        if (md_accept)
            md_cnt_next = MD_LOAD;
        else if (md_cnt != '0)
            md_cnt_next = md_cnt - CW'(1);
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!reset) begin
            if (mem_hold) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (state == MD_BUSY) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
            end else begin
                stall_f = lw_stall || br_stall;
                stall_d = lw_stall || br_stall;
                flush_e = lw_stall || br_stall;
            end
            flush_d = (pc_src_d || jump_d) && !stall_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall_f)
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e;
    logic [4:0]  write_reg_e, write_reg_m, write_reg_w;
    logic        reg_write_e, reg_write_m, reg_write_w;
    logic        mem_to_reg_e, mem_to_reg_m;
    logic        branch_d, pc_src_d, jump_d;
    logic        mem_req_m, mem_ready, md_start_e;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        forward_a_d, forward_b_d;
    logic [31:0] stall_cycles;

    // control field order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_HZ   = 7'b1100010;
    localparam logic [6:0] C_FD   = 7'b0000100;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_MD   = 7'b1110000;

    typedef struct {
        string       tag;
        logic [12:0] vec;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 0;
    logic [12:0] obs;

    hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .branch_d     (branch_d),
        .pc_src_d     (pc_src_d),
        .jump_d       (jump_d),
        .mem_req_m    (mem_req_m),
        .mem_ready    (mem_ready),
        .md_start_e   (md_start_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .forward_a_d  (forward_a_d),
        .forward_b_d  (forward_b_d),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_to_reg_e = 0; mem_to_reg_m = 0;
        branch_d = 0; pc_src_d = 0; jump_d = 0;
        mem_req_m = 0; mem_ready = 0; md_start_e = 0;
    endtask

    // Push the expected outputs for the cycle just driven, then sample mid-cycle and score.
    task automatic step(input string tag, input logic [6:0] ctl,
                        input logic [1:0] fae = 2'b00, input logic [1:0] fbe = 2'b00,
                        input logic fad = 1'b0, input logic fbd = 1'b0);
        exp_t x;
        x.tag = tag;
        x.vec = {ctl, fae, fbe, fad, fbd};
        x.cnt = model_cnt;
        sb.push_back(x);
        @(negedge clk);
        e = sb.pop_front();
        obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               forward_a_e, forward_b_e, forward_a_d, forward_b_d};
        checks++;
        assert (obs === e.vec) else begin
            errors++;
            $error("FAIL %s outputs observed %b expected %b", e.tag, obs, e.vec);
        end
        checks++;
        assert (stall_cycles === e.cnt) else begin
            errors++;
            $error("FAIL %s stall_cycles observed %0d expected %0d", e.tag, stall_cycles, e.cnt);
        end
        if (e.vec[12] && !reset) model_cnt = model_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        mem_req_m = 1; md_start_e = 1; pc_src_d = 1; mem_to_reg_e = 1;
        rs_e = 5; reg_write_m = 1; write_reg_m = 5;
        step("in_reset", C_NONE, 2'b10, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        idle();
        step("after_reset", C_NONE);

        rs_e = 5; reg_write_m = 1; write_reg_m = 5; reg_write_w = 1; write_reg_w = 5; rs_d = 5;
        step("fwd_m_prio", C_NONE, 2'b10, 2'b00, 1'b1, 1'b0);
        write_reg_m = 0;
        step("fwd_w_reg0m", C_NONE, 2'b01, 2'b00, 1'b0, 1'b0);
        idle();
        rs_e = 7; rt_e = 7; reg_write_m = 0; write_reg_m = 7; reg_write_w = 1; write_reg_w = 7; rt_d = 7;
        step("fwd_w_both", C_NONE, 2'b01, 2'b01, 1'b0, 1'b0);
        idle();
        reg_write_m = 1; reg_write_w = 1;
        step("fwd_zero_reg", C_NONE);
        idle();
        rt_e = 3; reg_write_m = 1; write_reg_m = 3; rt_d = 3;
        step("fwd_b_m", C_NONE, 2'b00, 2'b10, 1'b0, 1'b1);

        idle();
        mem_to_reg_e = 1; rt_e = 8; rs_d = 8;
        step("lw_rs", C_HZ);
        idle();
        rs_d = 8;
        step("lw_cleared", C_NONE);
        mem_to_reg_e = 1; rt_e = 9; rt_d = 9; rs_d = 0;
        step("lw_rt", C_HZ);

        idle();
        pc_src_d = 1;
        step("flush_pc", C_FD);
        idle();
        jump_d = 1;
        step("flush_jump", C_FD);
        idle();
        pc_src_d = 1; branch_d = 1; reg_write_e = 1; write_reg_e = 3; rs_d = 3;
        step("br_stall_e", C_HZ);
        idle();
        pc_src_d = 1; branch_d = 1; mem_to_reg_m = 1; write_reg_m = 4; rt_d = 4;
        step("br_stall_m", C_HZ);

        idle();
        mem_req_m = 1;
        step("mem_miss0", C_MEM);
        pc_src_d = 1;
        step("mem_miss1", C_MEM);
        pc_src_d = 0; mem_to_reg_e = 1; rt_e = 8; rs_d = 8;
        step("mem_miss2", C_MEM);
        idle();
        mem_req_m = 1; mem_ready = 1;
        step("mem_ready", C_MEM);
        idle();
        step("mem_done", C_NONE);

        md_start_e = 1;
        step("md_issue", C_NONE);
        idle();
        step("md_busy0", C_MD);
        pc_src_d = 1;
        step("md_busy1", C_MD);
        pc_src_d = 0;
        step("md_busy2", C_MD);
        step("md_busy3", C_MD);
        step("md_done", C_NONE);

        md_start_e = 1; mem_req_m = 1;
        step("both_miss", C_MEM);
        mem_ready = 1;
        step("both_ready", C_MEM);
        mem_req_m = 0; mem_ready = 0;
        step("md_held_issue", C_NONE);
        md_start_e = 0;
        for (int i = 0; i < 4; i++) step($sformatf("held_busy%0d", i), C_MD);
        step("held_done", C_NONE);

        md_start_e = 1;
        step("md_miss_issue", C_NONE);
        md_start_e = 0; mem_req_m = 1;
        step("md_miss_enter", C_MEM);
        step("md_miss_wait", C_MEM);
        mem_ready = 1;
        step("md_miss_ready", C_MEM);
        idle();
        step("md_resume", C_MD);
        step("md_resume_done", C_NONE);

        md_start_e = 1;
        step("sat_issue", C_NONE);
        md_start_e = 0; mem_req_m = 1;
        for (int i = 0; i < 4; i++) step($sformatf("sat_wait%0d", i), C_MEM);
        mem_ready = 1;
        step("sat_ready", C_MEM);
        idle();
        step("sat_run", C_NONE);

        md_start_e = 1;
        step("zero_issue", C_NONE);
        md_start_e = 0;
        for (int i = 0; i < 3; i++) step($sformatf("zero_busy%0d", i), C_MD);
        mem_req_m = 1;
        step("zero_miss", C_MEM);
        mem_ready = 1;
        step("zero_ready", C_MEM);
        idle();
        step("zero_run", C_NONE);

        md_start_e = 1;
        step("rst_issue", C_NONE);
        md_start_e = 0;
        step("rst_busy0", C_MD);
        reset = 1'b1;
        model_cnt = 0;
        step("rst_mid_md", C_NONE);
        reset = 1'b0;
        step("rst_release", C_NONE);
        step("rst_no_residual", C_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
